// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush and memory-wait freeze
// with a timeout escape and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       R1_D,
  input  logic [3:0]       R2_D,
  input  logic             Use_R1_D,
  input  logic             Use_R2_D,
  input  logic [3:0]       Rd_E,
  input  logic             MemRead_E,
  input  logic             Branch_Taken_E,
  input  logic             Mem_Req_M,
  input  logic             Mem_Ready_M,
  input  logic             Clear_Count,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mem_stall_s, load_use_s, hold_all_s, timeout_s;

  // R15 is the PC and never produces a load-use dependency
  assign mem_stall_s = Mem_Req_M & ~Mem_Ready_M;
  assign load_use_s  = MemRead_E & (Rd_E != 4'hF) &
                       ((Use_R1_D & (R1_D == Rd_E)) | (Use_R2_D & (R2_D == Rd_E)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold_all_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          hold_all_s = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          state_d    = RUN;
        end
      end
      MEM_WAIT: begin
        if (Mem_Ready_M) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          timeout_s  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          hold_all_s = 1'b1;
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Memory freeze dominates; a taken branch outranks load-use since the consumer is flushed anyway
  always_comb begin
    Stall_F     = 1'b0;
    Stall_D     = 1'b0;
    Stall_E     = 1'b0;
    Stall_M     = 1'b0;
    Flush_D     = 1'b0;
    Flush_E     = 1'b0;
    Mem_Timeout = 1'b0;
    if (rst) begin
      Mem_Timeout = 1'b0;
    end else if (hold_all_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
    end else begin
      Mem_Timeout = timeout_s;
      if (Branch_Taken_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (load_use_s) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end else begin
        Flush_E = 1'b0;
      end
    end
  end

  always_comb begin
    if (Clear_Count) begin
      count_d = '0;
    end else if (Stall_F && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
    end
  end

  assign Stall_Count = count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, hand-built multi-cycle sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  localparam int T  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] R1_D, R2_D, Rd_E;
  logic Use_R1_D, Use_R2_D, MemRead_E, Branch_Taken_E, Mem_Req_M, Mem_Ready_M, Clear_Count;
  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Mem_Timeout;
  logic [CW-1:0] Stall_Count;

  hazard_stall_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .R1_D(R1_D), .R2_D(R2_D), .Use_R1_D(Use_R1_D), .Use_R2_D(Use_R2_D),
    .Rd_E(Rd_E), .MemRead_E(MemRead_E), .Branch_Taken_E(Branch_Taken_E),
    .Mem_Req_M(Mem_Req_M), .Mem_Ready_M(Mem_Ready_M), .Clear_Count(Clear_Count),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Mem_Timeout(Mem_Timeout), .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r1, r2, rd;
    logic u1, u2, mr, br, req, rdy, clr;
    logic [6:0] exp_o;   // {SF,SD,SE,SM,FD,FE,TO}
    logic [3:0] exp_cnt; // Stall_Count during the cycle, before its edge
  } vec_t;

  int errors = 0;
  int checks = 0;

  // model state: consecutive cycles the current access has been held, and the stall tally
  int run_len = 0;
  int m_cnt   = 0;

  function automatic vec_t mk(input logic [3:0] r1, r2, rd, input logic u1, u2, mr, br, req, rdy, clr,
                              input logic [6:0] eo, input logic [3:0] ec);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.mr = mr; v.br = br;
    v.req = req; v.rdy = rdy; v.clr = clr; v.exp_o = eo; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic vec_t idle(input logic req, rdy, clr);
    return mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, req, rdy, clr, 7'd0, 4'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_o();
    return {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Mem_Timeout};
  endfunction

  // whether the memory side is still owed a wait this cycle
  function automatic bit model_pending(input vec_t v);
    return (run_len == 0) ? (v.req && !v.rdy) : !v.rdy;
  endfunction

  function automatic logic [6:0] model_out(input vec_t v);
    bit full, to, lu;
    logic [6:0] o;
    full = 1'b0; to = 1'b0; o = 7'd0;
    if (model_pending(v)) begin
      if (run_len == T) to = 1'b1;
      else full = 1'b1;
    end
    lu = v.mr && (v.rd != 4'd15) && ((v.u1 && v.r1 == v.rd) || (v.u2 && v.r2 == v.rd));
    if (full) o = 7'b1111000;
    else if (v.br) o = 7'b0000110;
    else if (lu) o = 7'b1100010;
    o[0] = to;
    return o;
  endfunction

  task automatic model_edge(input vec_t v, input logic [6:0] o);
    if (model_pending(v) && !o[0]) run_len = run_len + 1;
    else run_len = 0;
    if (v.clr) m_cnt = 0;
    else if (o[6] && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
  endtask

  // called 1 time unit after a rising edge; returns 1 after the next one
  task automatic step(input vec_t v, input bit use_tbl, input string name);
    logic [6:0] mo;
    R1_D = v.r1; R2_D = v.r2; Rd_E = v.rd; Use_R1_D = v.u1; Use_R2_D = v.u2;
    MemRead_E = v.mr; Branch_Taken_E = v.br; Mem_Req_M = v.req; Mem_Ready_M = v.rdy;
    Clear_Count = v.clr;
    #3;
    mo = model_out(v);
    if (use_tbl) begin
      chk({name, "_out"}, 32'(dut_o()), 32'(v.exp_o));
      chk({name, "_cnt"}, 32'(Stall_Count), 32'(v.exp_cnt));
    end else begin
      chk({name, "_out"}, 32'(dut_o()), 32'(mo));
      chk({name, "_cnt"}, 32'(Stall_Count), 32'(m_cnt));
    end
    @(posedge clk);
    model_edge(v, mo);
    #1;
  endtask

  vec_t tbl[12];
  vec_t seq[6];
  vec_t rv;

  initial begin
    rst = 1'b1;
    rv = idle(1'b0, 1'b0, 1'b0);
    R1_D = 4'd0; R2_D = 4'd0; Rd_E = 4'd0; Use_R1_D = 1'b0; Use_R2_D = 1'b0; MemRead_E = 1'b0;
    Branch_Taken_E = 1'b0; Mem_Req_M = 1'b1; Mem_Ready_M = 1'b0; Clear_Count = 1'b0;
    #2;
    chk("reset_out", 32'(dut_o()), 32'd0);
    chk("reset_cnt", 32'(Stall_Count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    tbl[0]  = idle(1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100010, 4'd0);
    tbl[2]  = mk(4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 4'd1);
    tbl[3]  = mk(4'd15, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 4'd1);
    tbl[4]  = mk(4'd0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000110, 4'd1);
    tbl[5]  = mk(4'd1, 4'd6, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 4'd1);
    tbl[6]  = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 4'd1);
    tbl[7]  = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111000, 4'd0);
    tbl[8]  = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111000, 4'd1);
    tbl[9]  = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111000, 4'd2);
    tbl[10] = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0000000, 4'd3);
    tbl[11] = idle(1'b0, 1'b0, 1'b0);
    tbl[11].exp_cnt = 4'd3;
    for (int i = 0; i < 12; i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // timeout: four stall cycles, one abandon pulse, then a fresh access
    seq[0] = idle(1'b0, 1'b0, 1'b1);
    seq[0].exp_cnt = 4'd3;
    for (int i = 1; i < 6; i++) begin
      seq[i] = idle(1'b1, 1'b0, 1'b0);
      seq[i].exp_o = (i == 5) ? 7'b0000001 : 7'b1111000;
      seq[i].exp_cnt = 4'(i - 1);
    end
    for (int i = 0; i < 6; i++) step(seq[i], 1'b1, $sformatf("tmo%0d", i));
    rv = idle(1'b1, 1'b0, 1'b0);
    rv.exp_o = 7'b1111000; rv.exp_cnt = 4'd4;
    step(rv, 1'b1, "tmo_new");

    // asynchronous reset in the middle of a wait
    #2 rst = 1'b1;
    #1;
    chk("amid_rst_out", 32'(dut_o()), 32'd0);
    chk("amid_rst_cnt", 32'(Stall_Count), 32'd0);
    run_len = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(idle(1'b0, 1'b0, 1'b0), 1'b0, "post_rst");

    // saturation: 25 cycles of a never-ready access give 20 stall cycles
    for (int i = 0; i < 25; i++) step(idle(1'b1, 1'b0, 1'b0), 1'b0, "sat");
    chk("sat_value", 32'(Stall_Count), 32'd15);
    step(idle(1'b1, 1'b0, 1'b1), 1'b0, "clr_in_stall");
    chk("clr_priority", 32'(Stall_Count), 32'd0);
    step(idle(1'b0, 1'b1, 1'b0), 1'b0, "drain");

    for (int i = 0; i < 500; i++) begin
      rv.r1 = 4'($urandom_range(0, 3)); rv.r2 = 4'($urandom_range(0, 3));
      rv.rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) rv.r1 = 4'd15;
      rv.u1 = 1'($urandom); rv.u2 = 1'($urandom); rv.mr = 1'($urandom);
      rv.br = ($urandom_range(0, 4) == 0); rv.req = ($urandom_range(0, 2) != 0);
      rv.rdy = ($urandom_range(0, 9) < 3); rv.clr = ($urandom_range(0, 30) == 0);
      step(rv, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
